// File: rtl/mem_access.sv
// Load/store stage after the ALU: passes ALU results to writeback, or runs
// one req/gnt/rvalid data-memory transaction with lane steering and extension.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_Valid_1,
    output logic        o_Ready_1,
    input  logic [31:0] i_ALUResult_32,
    input  logic [7:0]  i_MemControl_8,
    input  logic [31:0] i_StoreData_32,
    input  logic        i_RegWrite_1,
    input  logic [4:0]  i_RdAddr_5,
    output logic        o_WbValid_1,
    output logic        o_WbWe_1,
    output logic [4:0]  o_WbRd_5,
    output logic [31:0] o_WbData_32,
    output logic        o_StoreDone_1,
    output logic        o_MisalignErr_1,
    output logic        o_BusErr_1,
    output logic        o_MemReq_1,
    output logic        o_MemWe_1,
    output logic [31:0] o_MemAddr_32,
    output logic [31:0] o_MemWdata_32,
    output logic [3:0]  o_MemWstrb_4,
    input  logic        i_MemGnt_1,
    input  logic        i_MemRvalid_1,
    input  logic [31:0] i_MemRdata_32
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   addr_q;
    logic [31:0]   sdata_q;
    logic [4:0]    rd_q;
    logic          we_q;
    logic          store_q;
    logic          byte_q;
    logic          half_q;
    logic          sign_q;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          wb_valid_q, wb_valid_d;
    logic          wb_we_q, wb_we_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          sdone_q, sdone_d;
    logic          mis_q, mis_d;
    logic          bus_q, bus_d;
    logic          latch_en;

    // One-hot control {LB,LH,LW,LBU,LHU,SB,SH,SW} decoded by access size.
    logic in_mem, in_byte, in_half, in_word, in_store, in_sign, in_mis;
    logic accept, rd_nz, timeout_hit;

    assign in_mem   = |i_MemControl_8;
    assign in_byte  = i_MemControl_8[7] | i_MemControl_8[4]
                    | i_MemControl_8[2];
    assign in_half  = i_MemControl_8[6] | i_MemControl_8[3]
                    | i_MemControl_8[1];
    assign in_word  = i_MemControl_8[5] | i_MemControl_8[0];
    assign in_store = |i_MemControl_8[2:0];
    assign in_sign  = i_MemControl_8[7] | i_MemControl_8[6];
    assign in_mis   = (in_half & i_ALUResult_32[0])
                    | (in_word & (|i_ALUResult_32[1:0]));

    assign o_Ready_1   = (state_q == S_IDLE);
    assign accept      = i_Valid_1 & o_Ready_1;
    assign rd_nz       = |i_RdAddr_5;
    assign timeout_hit = (cnt_q >= CNT_LAST);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign ld_byte = i_MemRdata_32[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = addr_q[1] ? i_MemRdata_32[31:16]
                               : i_MemRdata_32[15:0];

    always_comb begin
        ld_data = i_MemRdata_32;
        if (byte_q) begin
            ld_data = {{24{sign_q & ld_byte[7]}}, ld_byte};
        end else if (half_q) begin
            ld_data = {{16{sign_q & ld_half[15]}}, ld_half};
        end
    end

    logic [3:0]  wstrb;
    logic [31:0] wdata;

    always_comb begin
        wstrb = 4'b1111;
        wdata = sdata_q;
        if (byte_q) begin
            wstrb = 4'b0001 << addr_q[1:0];
            wdata = {4{sdata_q[7:0]}};
        end else if (half_q) begin
            wstrb = 4'b0011 << addr_q[1:0];
            wdata = {2{sdata_q[15:0]}};
        end
    end

    assign o_MemReq_1    = (state_q == S_REQ);
    assign o_MemWe_1     = o_MemReq_1 & store_q;
    assign o_MemAddr_32  = o_MemReq_1 ? {addr_q[31:2], 2'b00} : 32'd0;
    assign o_MemWdata_32 = o_MemWe_1 ? wdata : 32'd0;
    assign o_MemWstrb_4  = o_MemWe_1 ? wstrb : 4'd0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch_en   = 1'b0;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        sdone_d    = 1'b0;
        mis_d      = 1'b0;
        bus_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!in_mem) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = i_RegWrite_1 & rd_nz;
                        wb_rd_d    = i_RdAddr_5;
                        wb_data_d  = i_ALUResult_32;
                    end else if (in_mis) begin
                        mis_d = 1'b1;
                    end else begin
                        latch_en = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // A grant on the final budgeted cycle still wins.
                if (i_MemGnt_1) begin
                    cnt_d = cnt_q + 1'b1;
                    if (store_q) begin
                        sdone_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (timeout_hit) begin
                    bus_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (i_MemRvalid_1) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = we_q;
                    wb_rd_d    = rd_q;
                    wb_data_d  = ld_data;
                    state_d    = S_IDLE;
                end else if (timeout_hit) begin
                    bus_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            store_q    <= 1'b0;
            byte_q     <= 1'b0;
            half_q     <= 1'b0;
            sign_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            sdone_q    <= 1'b0;
            mis_q      <= 1'b0;
            bus_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            sdone_q    <= sdone_d;
            mis_q      <= mis_d;
            bus_q      <= bus_d;
            if (latch_en) begin
                addr_q  <= i_ALUResult_32;
                sdata_q <= i_StoreData_32;
                rd_q    <= i_RdAddr_5;
                we_q    <= i_RegWrite_1 & rd_nz;
                store_q <= in_store;
                byte_q  <= in_byte;
                half_q  <= in_half;
                sign_q  <= in_sign;
            end
        end
    end

    assign o_WbValid_1     = wb_valid_q;
    assign o_WbWe_1        = wb_we_q;
    assign o_WbRd_5        = wb_rd_q;
    assign o_WbData_32     = wb_data_q;
    assign o_StoreDone_1   = sdone_q;
    assign o_MisalignErr_1 = mis_q;
    assign o_BusErr_1      = bus_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus randomized ops against an
// arithmetic model of lane steering, extension and timeout.
module tb_mem_access;

    localparam int TMO = 8;

    localparam logic [7:0] LB  = 8'h80;
    localparam logic [7:0] LH  = 8'h40;
    localparam logic [7:0] LW  = 8'h20;
    localparam logic [7:0] LBU = 8'h10;
    localparam logic [7:0] LHU = 8'h08;
    localparam logic [7:0] SB  = 8'h04;
    localparam logic [7:0] SH  = 8'h02;
    localparam logic [7:0] SW  = 8'h01;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_Valid_1;
    logic        o_Ready_1;
    logic [31:0] i_ALUResult_32;
    logic [7:0]  i_MemControl_8;
    logic [31:0] i_StoreData_32;
    logic        i_RegWrite_1;
    logic [4:0]  i_RdAddr_5;
    logic        o_WbValid_1;
    logic        o_WbWe_1;
    logic [4:0]  o_WbRd_5;
    logic [31:0] o_WbData_32;
    logic        o_StoreDone_1;
    logic        o_MisalignErr_1;
    logic        o_BusErr_1;
    logic        o_MemReq_1;
    logic        o_MemWe_1;
    logic [31:0] o_MemAddr_32;
    logic [31:0] o_MemWdata_32;
    logic [3:0]  o_MemWstrb_4;
    logic        i_MemGnt_1;
    logic        i_MemRvalid_1;
    logic [31:0] i_MemRdata_32;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_data = 0;
    logic [4:0]  last_rd = 0;

    mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_Valid_1(i_Valid_1), .o_Ready_1(o_Ready_1),
        .i_ALUResult_32(i_ALUResult_32),
        .i_MemControl_8(i_MemControl_8),
        .i_StoreData_32(i_StoreData_32),
        .i_RegWrite_1(i_RegWrite_1), .i_RdAddr_5(i_RdAddr_5),
        .o_WbValid_1(o_WbValid_1), .o_WbWe_1(o_WbWe_1),
        .o_WbRd_5(o_WbRd_5), .o_WbData_32(o_WbData_32),
        .o_StoreDone_1(o_StoreDone_1),
        .o_MisalignErr_1(o_MisalignErr_1),
        .o_BusErr_1(o_BusErr_1),
        .o_MemReq_1(o_MemReq_1), .o_MemWe_1(o_MemWe_1),
        .o_MemAddr_32(o_MemAddr_32),
        .o_MemWdata_32(o_MemWdata_32),
        .o_MemWstrb_4(o_MemWstrb_4),
        .i_MemGnt_1(i_MemGnt_1), .i_MemRvalid_1(i_MemRvalid_1),
        .i_MemRdata_32(i_MemRdata_32)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int size_of(input logic [7:0] c);
        if (c == LB || c == LBU || c == SB) return 1;
        if (c == LH || c == LHU || c == SH) return 2;
        if (c == LW || c == SW) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [7:0] c,
        input logic [31:0] a, input logic [31:0] rd);
        int sz;
        logic [31:0] v, m;
        sz = size_of(c);
        if (sz == 4) return rd;
        v = rd >> (8 * (a % 4));
        m = (32'd1 << (8 * sz)) - 1;
        v = v & m;
        if ((c == LB || c == LH) && ((v >> (8 * sz - 1)) & 1) == 1)
            v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] exp_wstrb(input int sz,
        input logic [31:0] a);
        if (sz == 4) return 32'hF;
        return (((32'd1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input int sz,
        input logic [31:0] d);
        if (sz == 1) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    task automatic idle_check();
        tick();
        chk("idle_ready", o_Ready_1, 1);
        chk("idle_pulses", {o_WbValid_1, o_StoreDone_1,
            o_MisalignErr_1, o_BusErr_1, o_MemReq_1}, 0);
        chk("hold_data", o_WbData_32, last_data);
        chk("hold_rd", o_WbRd_5, last_rd);
    endtask

    task automatic do_op(input logic [7:0] c, input logic [31:0] a,
        input logic [31:0] d, input logic rw, input logic [4:0] rd,
        input int g, input int r, input logic [31:0] rdata);
        int sz;
        bit st;
        sz = size_of(c);
        st = (c == SB || c == SH || c == SW);
        chk("ready_pre", o_Ready_1, 1);
        i_Valid_1 = 1;
        i_MemControl_8 = c;
        i_ALUResult_32 = a;
        i_StoreData_32 = d;
        i_RegWrite_1 = rw;
        i_RdAddr_5 = rd;
        tick();
        i_Valid_1 = 0;
        if (sz == 0) begin
            chk("alu_wbv", o_WbValid_1, 1);
            chk("alu_we", o_WbWe_1, rw && rd != 0);
            chk("alu_rd", o_WbRd_5, rd);
            chk("alu_data", o_WbData_32, a);
            last_data = a;
            last_rd = rd;
        end else if (a % sz != 0) begin
            chk("mis_pulse", o_MisalignErr_1, 1);
            chk("mis_noreq", o_MemReq_1, 0);
            chk("mis_nowb", o_WbValid_1, 0);
            chk("mis_ready", o_Ready_1, 1);
        end else begin
            for (int i = 1; i <= g; i++) begin
                chk("req", o_MemReq_1, 1);
                chk("req_ready", o_Ready_1, 0);
                chk("req_addr", o_MemAddr_32, a & 32'hFFFFFFFC);
                chk("req_we", o_MemWe_1, st);
                chk("req_wstrb", o_MemWstrb_4, st ? exp_wstrb(sz, a) : 0);
                if (st) chk("req_wdata", o_MemWdata_32, exp_wdata(sz, d));
                i_MemGnt_1 = (i == g);
                tick();
                i_MemGnt_1 = 0;
            end
            if (st) begin
                chk("st_done", o_StoreDone_1, 1);
                chk("st_noreq", o_MemReq_1, 0);
                chk("st_nowb", o_WbValid_1, 0);
            end else begin
                for (int j = 1; j <= r; j++) begin
                    chk("wait_noreq", o_MemReq_1, 0);
                    chk("wait_nowb", o_WbValid_1, 0);
                    chk("wait_ready", o_Ready_1, 0);
                    i_MemRvalid_1 = (j == r);
                    i_MemRdata_32 = rdata;
                    tick();
                    i_MemRvalid_1 = 0;
                    i_MemRdata_32 = $urandom;
                end
                chk("ld_wbv", o_WbValid_1, 1);
                chk("ld_we", o_WbWe_1, rw && rd != 0);
                chk("ld_rd", o_WbRd_5, rd);
                chk("ld_data", o_WbData_32, exp_load(c, a, rdata));
                last_data = exp_load(c, a, rdata);
                last_rd = rd;
            end
        end
        idle_check();
    endtask

    task automatic timeout_op(input logic [7:0] c, input logic [31:0] a,
                              input int g);
        chk("to_ready_pre", o_Ready_1, 1);
        i_Valid_1 = 1;
        i_MemControl_8 = c;
        i_ALUResult_32 = a;
        i_RdAddr_5 = 5'd3;
        i_RegWrite_1 = 1;
        tick();
        i_Valid_1 = 0;
        for (int i = 1; i <= TMO; i++) begin
            chk("to_busy", {o_Ready_1, o_BusErr_1, o_WbValid_1}, 0);
            chk("to_req", o_MemReq_1, (g == 0) || (i <= g));
            i_MemGnt_1 = (i == g);
            tick();
            i_MemGnt_1 = 0;
        end
        chk("to_buserr", o_BusErr_1, 1);
        chk("to_noreq", o_MemReq_1, 0);
        chk("to_nowb", o_WbValid_1, 0);
        chk("to_ready", o_Ready_1, 1);
        idle_check();
    endtask

    initial begin
        logic [7:0] ctls [9];
        logic [7:0] c;
        logic [31:0] a;
        ctls = '{8'h00, LB, LH, LW, LBU, LHU, SB, SH, SW};
        rst = 1;
        i_Valid_1 = 0;
        i_ALUResult_32 = 0;
        i_MemControl_8 = 0;
        i_StoreData_32 = 0;
        i_RegWrite_1 = 0;
        i_RdAddr_5 = 0;
        i_MemGnt_1 = 0;
        i_MemRvalid_1 = 0;
        i_MemRdata_32 = 0;
        tick();
        tick();
        chk("rst_ready", o_Ready_1, 1);
        chk("rst_outs", {o_WbValid_1, o_WbWe_1, o_StoreDone_1,
            o_MisalignErr_1, o_BusErr_1, o_MemReq_1, o_MemWe_1}, 0);
        chk("rst_bus", o_MemAddr_32 | o_MemWdata_32 | o_MemWstrb_4, 0);
        chk("rst_wb", {o_WbRd_5, o_WbData_32}, 0);
        rst = 0;
        tick();

        i_Valid_1 = 1;
        i_MemControl_8 = 0;
        i_RegWrite_1 = 1;
        i_ALUResult_32 = 32'h1234;
        i_RdAddr_5 = 5;
        tick();
        chk("b2b_v1", {o_WbValid_1, o_WbWe_1}, 2'b11);
        chk("b2b_d1", {o_WbRd_5, o_WbData_32}, {5'd5, 32'h1234});
        i_ALUResult_32 = 32'h5678;
        i_RdAddr_5 = 6;
        tick();
        i_Valid_1 = 0;
        chk("b2b_v2", {o_WbValid_1, o_WbWe_1}, 2'b11);
        chk("b2b_d2", {o_WbRd_5, o_WbData_32}, {5'd6, 32'h5678});
        last_data = 32'h5678;
        last_rd = 6;
        idle_check();

        do_op(SB, 32'h103, 32'hAB, 0, 0, 3, 0, 0);
        do_op(LB, 32'h102, 0, 1, 7, 1, 2, 32'h0080_0000);
        chk("lb_dir", o_WbData_32, 32'hFFFFFF80);
        do_op(LBU, 32'h102, 0, 1, 8, 2, 1, 32'h0080_0000);
        chk("lbu_dir", o_WbData_32, 32'h00000080);
        do_op(LH, 32'h102, 0, 1, 9, 1, 1, 32'h8001_0000);
        chk("lh_dir", o_WbData_32, 32'hFFFF8001);
        do_op(LW, 32'h102, 0, 1, 10, 1, 1, 0);
        do_op(LW, 32'h200, 0, 1, 0, 1, 3, 32'hCAFE_F00D);
        chk("rd0_we", o_WbWe_1, 0);
        do_op(SH, 32'h202, 32'h1234_BEEF, 0, 0, 1, 0, 0);

        timeout_op(LW, 32'h300, 2);
        do_op(8'h00, 32'h77, 0, 1, 4, 0, 0, 0);
        timeout_op(SW, 32'h304, 0);

        i_Valid_1 = 1;
        i_MemControl_8 = LW;
        i_ALUResult_32 = 32'h400;
        tick();
        i_Valid_1 = 0;
        i_MemGnt_1 = 1;
        tick();
        i_MemGnt_1 = 0;
        tick();
        rst = 1;
        i_MemRvalid_1 = 1;
        tick();
        rst = 0;
        i_MemRvalid_1 = 0;
        chk("rstw_req", o_MemReq_1, 0);
        chk("rstw_wb", {o_WbValid_1, o_BusErr_1}, 0);
        chk("rstw_ready", o_Ready_1, 1);
        last_data = 0;
        last_rd = 0;
        idle_check();

        for (int n = 0; n < 60; n++) begin
            c = ctls[$urandom_range(0, 8)];
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            do_op(c, a, $urandom, 1'($urandom), 5'($urandom),
                  $urandom_range(1, 3), $urandom_range(1, 3), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
